// File: rtl/rob_cpl_pkg.sv
// Shared types and the round-robin search helper for the ROB completion arbiter.
package rob_cpl_pkg;

  localparam int unsigned CPL_INUM_W = 32;
  localparam int unsigned RR_MAX_REQ = 32;
  localparam int unsigned RR_IDX_W   = 5;

  typedef struct packed {
    logic [CPL_INUM_W-1:0] instr_num;
    logic                  alt_req;
    logic [31:0]           alt_pc;
  } cpl_entry_t;

  // First set bit of elig at or after start, wrapping at n-1; 0 when elig is empty.
  function automatic int unsigned rr_pick(input logic [RR_MAX_REQ-1:0] elig,
                                          input int unsigned           start,
                                          input int unsigned           n);
    int unsigned idx;
    int unsigned res;
    logic        found;
    res   = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < RR_MAX_REQ; i++) begin
      idx = start + i;
      if (idx >= n) idx = idx - n;
      if (i < n && !found && elig[idx[RR_IDX_W-1:0]]) begin
        found = 1'b1;
        res   = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rob_cpl_fifo.sv
// Per-requester completion FIFO: DEPTH entries, synchronous flush, head read combinationally.
module rob_cpl_fifo
  import rob_cpl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  cpl_entry_t             din_i,
  output logic [$clog2(DEPTH):0] count_o,
  output cpl_entry_t             head_c_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  cpl_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign count_o  = count_q;
  assign head_c_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/rob_cpl_arbiter.sv
// Round-robin arbiter of functional-unit completion reports onto the ROB completion port.
// Define ROB_CPL_MISPRED_PRIO_EN to favour heads carrying an alternate-PC request.
module rob_cpl_arbiter
  import rob_cpl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned INUM_W  = CPL_INUM_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       stall,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*INUM_W-1:0]  req_instr_num,
  input  logic [NUM_REQ-1:0]         req_alt_req,
  input  logic [NUM_REQ*32-1:0]      req_alt_pc,
  output logic                       cpl_valid,
  output logic [INUM_W-1:0]          cpl_instr_num,
  output logic                       cpl_alt_req,
  output logic [31:0]                cpl_alt_pc,
  output logic [$clog2(NUM_REQ)-1:0] cpl_src
);

  localparam int unsigned SRC_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic       [NUM_REQ-1:0]            push;
  logic       [NUM_REQ-1:0]            pop;
  logic       [NUM_REQ-1:0][CNT_W-1:0] count;
  cpl_entry_t [NUM_REQ-1:0]            head;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] cand;
  logic               grant_c;
  logic [SRC_W-1:0]   gidx;

  logic             cpl_valid_q, cpl_valid_d;
  cpl_entry_t       cpl_q, cpl_d;
  logic [SRC_W-1:0] cpl_src_q, cpl_src_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_req
    cpl_entry_t in_ent;

    // Ready comes from the registered count only, so a popping full FIFO stays not-ready this cycle.
    assign req_ready[k] = (count[k] != CNT_W'(DEPTH));
    assign push[k]      = req_valid[k] & req_ready[k];
    assign in_ent       = '{instr_num: CPL_INUM_W'(req_instr_num[k*INUM_W +: INUM_W]),
                            alt_req:   req_alt_req[k],
                            alt_pc:    req_alt_pc[k*32 +: 32]};

    rob_cpl_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (reset),
      .flush_i  (flush),
      .push_i   (push[k]),
      .pop_i    (pop[k]),
      .din_i    (in_ent),
      .count_o  (count[k]),
      .head_c_o (head[k])
    );
  end

  // Grant selection and next-state of the output registers and rr pointer.
  always_comb begin
    elig        = '0;
    cand        = '0;
    pop         = '0;
    grant_c     = 1'b0;
    gidx        = '0;
    cpl_valid_d = 1'b0;
    cpl_d       = cpl_q;
    cpl_src_d   = cpl_src_q;
    rr_ptr_d    = rr_ptr_q;

    for (int k = 0; k < NUM_REQ; k++) begin
      elig[k] = (count[k] != '0) && !stall && !flush;
    end
    cand = elig;
`ifdef ROB_CPL_MISPRED_PRIO_EN
    begin
      logic [NUM_REQ-1:0] prio;
      for (int k = 0; k < NUM_REQ; k++) begin
        prio[k] = elig[k] & head[k].alt_req;
      end
      if (|prio) cand = prio;
    end
`endif
    grant_c = |cand;
    gidx    = SRC_W'(rr_pick(RR_MAX_REQ'(cand), 32'(rr_ptr_q), NUM_REQ));

    if (grant_c) begin
      pop[gidx]   = 1'b1;
      cpl_valid_d = 1'b1;
      cpl_d       = head[gidx];
      cpl_src_d   = gidx;
      rr_ptr_d    = (gidx == SRC_W'(NUM_REQ - 1)) ? '0 : gidx + SRC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpl_valid_q <= 1'b0;
      cpl_q       <= '0;
      cpl_src_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      cpl_valid_q <= cpl_valid_d;
      cpl_q       <= cpl_d;
      cpl_src_q   <= cpl_src_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign cpl_valid     = cpl_valid_q;
  assign cpl_instr_num = INUM_W'(cpl_q.instr_num);
  assign cpl_alt_req   = cpl_q.alt_req;
  assign cpl_alt_pc    = cpl_q.alt_pc;
  assign cpl_src       = cpl_src_q;

endmodule

// File: tb/tb_rob_cpl_arbiter.sv
// Self-checking bench for rob_cpl_arbiter: directed scenarios plus randomized traffic
// against a queue-based reference model. Honours ROB_CPL_MISPRED_PRIO_EN like the design.
module tb_rob_cpl_arbiter;

  localparam int NR    = 4;
  localparam int DEPTH = 4;
  localparam int IW    = 32;

  typedef struct packed {
    logic [IW-1:0] inum;
    logic          alt;
    logic [31:0]   pc;
  } ent_t;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             stall;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*IW-1:0] req_instr_num;
  logic [NR-1:0]    req_alt_req;
  logic [NR*32-1:0] req_alt_pc;
  logic             cpl_valid;
  logic [IW-1:0]    cpl_instr_num;
  logic             cpl_alt_req;
  logic [31:0]      cpl_alt_pc;
  logic [1:0]       cpl_src;

  rob_cpl_arbiter #(.NUM_REQ(NR), .DEPTH(DEPTH), .INUM_W(IW)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .stall         (stall),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_instr_num (req_instr_num),
    .req_alt_req   (req_alt_req),
    .req_alt_pc    (req_alt_pc),
    .cpl_valid     (cpl_valid),
    .cpl_instr_num (cpl_instr_num),
    .cpl_alt_req   (cpl_alt_req),
    .cpl_alt_pc    (cpl_alt_pc),
    .cpl_src       (cpl_src)
  );

  // Reference model: one queue per requester plus the expected output register contents.
  ent_t      mq[NR][$];
  int        rr_m;
  logic      exp_valid;
  ent_t      exp_e;
  int        exp_src;
  logic [NR-1:0] last_acc;
  bit        pend_v[NR];
  ent_t      pend_e[NR];
  int        n_checks;
  int        n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_checks++;
    if (obs !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, want, $time);
    end
  endtask

  function automatic ent_t mk(input logic [IW-1:0] n, input logic a, input logic [31:0] pc);
    ent_t e;
    e = '{inum: n, alt: a, pc: pc};
    return e;
  endfunction

  task automatic drive_req(input int k, input ent_t e);
    req_valid[k]              = 1'b1;
    req_instr_num[k*IW +: IW] = e.inum;
    req_alt_req[k]            = e.alt;
    req_alt_pc[k*32 +: 32]    = e.pc;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NR; k++) begin
      mq[k].delete();
      pend_v[k] = 1'b0;
    end
    rr_m      = 0;
    exp_valid = 1'b0;
    exp_e     = '0;
    exp_src   = 0;
    last_acc  = '0;
  endtask

  task automatic check_outputs();
    logic [NR-1:0] er;
    for (int k = 0; k < NR; k++) er[k] = (mq[k].size() != DEPTH);
    chk("cpl_valid",     64'(cpl_valid),     64'(exp_valid));
    chk("cpl_instr_num", 64'(cpl_instr_num), 64'(exp_e.inum));
    chk("cpl_alt_req",   64'(cpl_alt_req),   64'(exp_e.alt));
    chk("cpl_alt_pc",    64'(cpl_alt_pc),    64'(exp_e.pc));
    chk("cpl_src",       64'(cpl_src),       64'(exp_src));
    chk("req_ready",     64'(req_ready),     64'(er));
  endtask

  // Predict one clock edge from the current inputs, advance, then compare.
  task automatic step();
    logic [NR-1:0] rdy, el, acc;
    int            g;
    int            idx;
    bit            found;
`ifdef ROB_CPL_MISPRED_PRIO_EN
    logic [NR-1:0] pr;
`endif
    for (int k = 0; k < NR; k++) begin
      rdy[k] = (mq[k].size() != DEPTH);
      acc[k] = req_valid[k] && rdy[k];
      el[k]  = (mq[k].size() != 0) && !stall && !flush;
    end
`ifdef ROB_CPL_MISPRED_PRIO_EN
    for (int k = 0; k < NR; k++) pr[k] = el[k] && (mq[k].size() != 0) && mq[k][0].alt;
    if (pr != '0) el = pr;
`endif
    found = 1'b0;
    g     = 0;
    for (int i = 0; i < NR; i++) begin
      idx = (rr_m + i) % NR;
      if (!found && el[idx]) begin
        found = 1'b1;
        g     = idx;
      end
    end
    if (flush) begin
      for (int k = 0; k < NR; k++) mq[k].delete();
      exp_valid = 1'b0;
    end else begin
      if (found) begin
        exp_e     = mq[g].pop_front();
        exp_valid = 1'b1;
        exp_src   = g;
        rr_m      = (g + 1) % NR;
      end else begin
        exp_valid = 1'b0;
      end
      for (int k = 0; k < NR; k++)
        if (acc[k]) mq[k].push_back(mk(req_instr_num[k*IW +: IW], req_alt_req[k], req_alt_pc[k*32 +: 32]));
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    reset         = 1'b0;
    flush         = 1'b0;
    stall         = 1'b0;
    req_valid     = '0;
    req_instr_num = '0;
    req_alt_req   = '0;
    req_alt_pc    = '0;
    model_reset();
    @(negedge clk);
    check_outputs();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Reset asserted between edges must clear state without waiting for a clock.
  task automatic async_reset_check();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    req_valid = '0;
    flush     = 1'b0;
    stall     = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int   n;
    ent_t got[$];
    n_checks = 0;
    n_errors = 0;

    // Single report, minimum latency.
    do_reset();
    drive_req(1, mk(32'h05, 1'b0, 32'h0));
    step();
    req_valid = '0;
    step();
    chk("t1_valid", 64'(cpl_valid), 64'd1);
    chk("t1_inum",  64'(cpl_instr_num), 64'h05);
    chk("t1_src",   64'(cpl_src), 64'd1);
    step();
    chk("t1_valid_off", 64'(cpl_valid), 64'd0);

    // All requesters at once from rr_ptr 0.
    do_reset();
    for (int k = 0; k < NR; k++) drive_req(k, mk(IW'(10 + k), 1'b0, 32'h1000 + 32'(k)));
    step();
    req_valid = '0;
    for (int i = 0; i < NR; i++) begin
      step();
      chk("t2_order", 64'(cpl_instr_num), 64'(10 + i));
    end
    step();
    chk("t2_idle", 64'(cpl_valid), 64'd0);

    // Fill requester 2 under stall, hold the fifth, then drain.
    stall = 1'b1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      if (n < 5) drive_req(2, mk(IW'(100 + n), 1'b0, 32'h2000 + 32'(n)));
      else req_valid = '0;
      step();
      if (last_acc[2]) n++;
    end
    chk("t3_pushed", 64'(n), 64'd4);
    chk("t3_ready2", 64'(req_ready[2]), 64'd0);
    stall = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (n < 5) drive_req(2, mk(IW'(100 + n), 1'b0, 32'h2000 + 32'(n)));
      else req_valid = '0;
      step();
      if (cpl_valid) got.push_back(mk(cpl_instr_num, cpl_alt_req, cpl_alt_pc));
      if (last_acc[2]) n++;
    end
    chk("t3_drain_cnt", 64'(got.size()), 64'd5);
    for (int i = 0; i < got.size() && i < 5; i++) chk("t3_drain", 64'(got[i].inum), 64'(100 + i));

    // Stall holds buffered reports, then flush discards them.
    stall = 1'b1;
    for (int k = 0; k < 3; k++) drive_req(k, mk(IW'(200 + k), 1'b1, 32'h3000));
    step();
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t4_stall_valid", 64'(cpl_valid), 64'd0);
    end
    stall = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t4_flush_valid", 64'(cpl_valid), 64'd0);
    end
    chk("t4_ready", 64'(req_ready), 64'hf);

    // Alternate-PC priority against a plain round-robin winner.
    do_reset();
    drive_req(0, mk(IW'(20), 1'b0, 32'h0));
    drive_req(3, mk(IW'(23), 1'b1, 32'h0040_0100));
    step();
    req_valid = '0;
    step();
`ifdef ROB_CPL_MISPRED_PRIO_EN
    chk("t5_src", 64'(cpl_src), 64'd3);
    chk("t5_pc",  64'(cpl_alt_pc), 64'h0040_0100);
`else
    chk("t5_src", 64'(cpl_src), 64'd0);
    chk("t5_inum", 64'(cpl_instr_num), 64'd20);
`endif
    step();
    step();

    // Randomized traffic with stalls, flushes and one asynchronous reset.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) async_reset_check();
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 39) == 0);
      for (int k = 0; k < NR; k++) begin
        if (!pend_v[k] && $urandom_range(0, 2) != 0) begin
          pend_v[k] = 1'b1;
          pend_e[k] = mk($urandom, ($urandom_range(0, 3) == 0), $urandom);
        end
        if (pend_v[k]) drive_req(k, pend_e[k]);
        else req_valid[k] = 1'b0;
      end
      step();
      for (int k = 0; k < NR; k++) if (last_acc[k]) pend_v[k] = 1'b0;
    end
    flush     = 1'b0;
    stall     = 1'b0;
    req_valid = '0;
    repeat (20) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rob_cpl_arbiter.md
# rob_cpl_arbiter

Arbitrates completion reports from up to NUM_REQ functional units (ALU, branch, LSQ, HI/LO unit) onto the ROB's single completion port. Each requester has a small FIFO so a unit never has to drop a report it has finished. The arbiter issues at most one registered report per cycle, in round-robin order, and discards every buffered report on a pipeline flush. It sits between the execute/memory stages and the ROB completion inputs.

## Interface
- NUM_REQ, 4: number of requesters; minimum 2.
- DEPTH, 4: per-requester FIFO entries; power of two.
- INUM_W, 32: instruction-number width.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-low.
- flush  in  1  pipeline flush from the ROB.
- stall  in  1  when high, nothing is granted this cycle.
- req_valid  in  NUM_REQ  completion report valid, one bit per requester.
- req_ready  out  NUM_REQ  requester FIFO can accept a report.
- req_instr_num  in  NUM_REQ*INUM_W  instruction number; requester k uses slice k.
- req_alt_req  in  NUM_REQ  misprediction / alternate-PC request.
- req_alt_pc  in  NUM_REQ*32  alternate PC.
- cpl_valid  out  1  completion report to the ROB.
- cpl_instr_num  out  INUM_W  reported instruction number.
- cpl_alt_req  out  1  reported alternate-PC request.
- cpl_alt_pc  out  32  reported alternate PC.
- cpl_src  out  $clog2(NUM_REQ)  index of the granted requester (debug).

## Operation
- Enqueue: requester k writes when req_valid[k] & req_ready[k] at posedge clk.
- req_ready[k] = (count[k] != DEPTH). It depends only on registered count[k], never on req_valid.
- Eligible set: FIFOs with count != 0, masked to none when stall=1 or flush=1.
- Grant: search the eligible set starting at rr_ptr, wrapping at NUM_REQ-1 to 0; the first eligible index wins.
- On a grant to index g:
  - pop the head of FIFO g;
  - load its entry into the cpl_* registers and set cpl_src = g;
  - set rr_ptr = (g+1) mod NUM_REQ.
- No grant: cpl_valid = 0, other cpl_* hold their previous values, rr_ptr unchanged.
- Simultaneous push and pop on the same FIFO: count unchanged; both pointers advance.
- A full FIFO that pops in a cycle still shows req_ready = 0 in that cycle. Ready rises in the next cycle.
- Flush: at the posedge where flush=1:
  - all counts and read/write pointers go to 0;
  - pushes presented in that cycle are dropped;
  - cpl_valid = 0 in the following cycle;
  - rr_ptr is unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- A req_valid with req_ready = 0 is not accepted. The requester must hold the report until it is accepted.

## Timing
- Reset values: cpl_valid 0, cpl_instr_num 0, cpl_alt_req 0, cpl_alt_pc 0, cpl_src 0, rr_ptr 0, all counts 0. req_ready is all ones once reset is released.
- Latency: a report accepted at edge N appears on cpl_* during cycle N+1 at the earliest. There is no combinational bypass.
- Throughput: one report per cycle in aggregate. A single requester can sustain one report per cycle when no other requester is eligible.
- Fairness: with all requesters continuously eligible, every requester is granted once every NUM_REQ cycles.
- If reset asserts mid-operation, all state clears immediately (asynchronous reset).

## Configuration
- ROB_CPL_MISPRED_PRIO_EN:
  - Defined: eligible FIFO heads with alt_req=1 form a priority set. If that set is non-empty, round-robin starting at rr_ptr is applied within it only. rr_ptr updates as normal.
  - Undefined: plain round-robin over all eligible FIFOs.

## Structure
- Package rob_cpl_pkg holds:
  - INUM_W default;
  - cpl_entry_t struct {instr_num, alt_req, alt_pc};
  - the function that computes the round-robin index.
- Sub-module rob_cpl_fifo: one synchronous FIFO of DEPTH entries, with push, pop, flush, count and head outputs, instantiated NUM_REQ times.
- The top level contains only the grant logic, rr_ptr and the output registers.

## Test plan
- Reset, then requester 1 pushes instr 0x05 in cycle 0 -> cpl_valid=1, instr_num=0x05, cpl_src=1 in cycle 1; cpl_valid=0 in cycle 2.
- All 4 requesters push simultaneously (instrs 10, 11, 12, 13), rr_ptr=0 -> grant order 10, 11, 12, 13 on consecutive cycles.
- Requester 2 pushes 5 reports with no grants (stall=1) -> req_ready[2]=0 after the 4th push, 5th held; releasing stall drains all 5 in order.
- 3 reports buffered, flush=1 for one cycle -> no cpl_valid afterwards, counts 0, req_ready all ones.
- With ROB_CPL_MISPRED_PRIO_EN, rr_ptr=0, requester 0 head alt_req=0 and requester 3 head alt_req=1 (alt_pc 0x400100) -> requester 3 granted first, cpl_alt_pc=0x400100; without the macro, requester 0 is granted first.
- stall=1 with FIFOs non-empty for 3 cycles -> cpl_valid=0 throughout; counts and rr_ptr unchanged.
